// File: rtl/pc_sel_ctrl.sv
// rtl/pc_sel_ctrl.sv - PC-source sequencer: PC-next select, PC write enable and exception vector fetch
module pc_sel_ctrl #(
  parameter logic [63:0] EXC_VEC_OPCODE = 64'd254,
  parameter logic [63:0] EXC_VEC_OVF    = 64'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_done,
  input  logic        branch_taken,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic [63:0] pc_current,
  input  logic        vec_ack,
  output logic [1:0]  mux_pc_signal,
  output logic        pc_write,
  output logic        vec_req,
  output logic [63:0] vec_addr,
  output logic [63:0] epc,
  output logic [1:0]  cause,
  output logic        exc_active,
  output logic [7:0]  exc_count
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    EXC_FETCH = 2'd1,
    EXC_LOAD  = 2'd2
  } state_t;

  localparam logic [1:0] SEL_SEQ    = 2'd0;
  localparam logic [1:0] SEL_BRANCH = 2'd1;
  localparam logic [1:0] SEL_EXC    = 2'd2;

  localparam logic [1:0] CAUSE_OPCODE   = 2'd1;
  localparam logic [1:0] CAUSE_OVERFLOW = 2'd2;

  state_t state;
  state_t state_next;
  logic   exc_take;

  // An exception is only recognised at an instruction boundary while running
  assign exc_take = (state == RUN) && instr_done && (exc_opcode || exc_overflow);

  // State register; reset aborts any in-flight exception sequence
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Exception bookkeeping: capture faulting PC and cause, count with saturation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      epc       <= 64'd0;
      cause     <= 2'd0;
      exc_count <= 8'd0;
    end else if (exc_take) begin
      epc       <= pc_current;
      cause     <= exc_opcode ? CAUSE_OPCODE : CAUSE_OVERFLOW;
      if (exc_count != 8'hff) begin
        exc_count <= exc_count + 8'd1;
      end
    end
  end

  // Next state and outputs; exception outputs depend on registered state only
  always_comb begin
    state_next    = state;
    pc_write      = 1'b0;
    mux_pc_signal = SEL_SEQ;
    vec_req       = 1'b0;
    vec_addr      = 64'd0;
    exc_active    = 1'b0;
    case (state)
      RUN: begin
        if (exc_take) begin
          state_next = EXC_FETCH;
        end else if (instr_done && reset) begin
          // gated by reset so nothing loads the PC while reset is held
          pc_write      = 1'b1;
          mux_pc_signal = branch_taken ? SEL_BRANCH : SEL_SEQ;
        end
      end
      EXC_FETCH: begin
        exc_active = 1'b1;
        vec_req    = 1'b1;
        vec_addr   = (cause == CAUSE_OPCODE) ? EXC_VEC_OPCODE : EXC_VEC_OVF;
        if (vec_ack) begin
          state_next = EXC_LOAD;
        end
      end
      EXC_LOAD: begin
        exc_active    = 1'b1;
        pc_write      = 1'b1;
        mux_pc_signal = SEL_EXC;
        state_next    = RUN;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

endmodule
